// File: rtl/cmp_sequencer.sv
// Multi-byte compare controller: walks two latched NBYTES-wide operands MSB-first
// through one shared 8-bit comparator, stopping at the first differing byte.
// Latency: k edges from accept to done (k = bytes examined, 1..NBYTES); start ignored while busy.

// 8-bit magnitude comparator; i_sign selects two's-complement ordering.
module comparator (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_sign,
   output logic       o_eq,
   output logic       o_lt,
   output logic       o_gt
);

   logic [7:0] w_a_adj;
   logic [7:0] w_b_adj;

   // Flipping the MSB maps signed ordering onto unsigned ordering.
   always_comb begin
      w_a_adj = {i_a[7] ^ i_sign, i_a[6:0]};
      w_b_adj = {i_b[7] ^ i_sign, i_b[6:0]};
      o_eq    = (i_a == i_b);
      o_lt    = (w_a_adj < w_b_adj);
      o_gt    = (w_a_adj > w_b_adj);
   end

endmodule

module cmp_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sign,
   input  logic                abort,
   input  logic [8*NBYTES-1:0] a_bus,
   input  logic [8*NBYTES-1:0] b_bus,
   output logic                busy,
   output logic                done,
   output logic                eq,
   output logic                lt,
   output logic                gt
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NBYTES - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CMP  = 1'b1
   } state_t;

   state_t              r_state;
   logic [8*NBYTES-1:0] r_a;
   logic [8*NBYTES-1:0] r_b;
   logic                r_sign;
   logic [IW-1:0]       r_idx;
   logic                r_done;
   logic                r_eq;
   logic                r_lt;
   logic                r_gt;

   state_t              w_state_nxt;
   logic [8*NBYTES-1:0] w_a_nxt;
   logic [8*NBYTES-1:0] w_b_nxt;
   logic                w_sign_nxt;
   logic [IW-1:0]       w_idx_nxt;
   logic                w_done_nxt;
   logic                w_eq_nxt;
   logic                w_lt_nxt;
   logic                w_gt_nxt;

   logic [7:0]          w_a_byte;
   logic [7:0]          w_b_byte;
   logic                w_byte_sign;
   logic                w_byte_eq;
   logic                w_byte_lt;
   logic                w_byte_gt;

   // Select the current byte; only the most significant byte carries the sign bit.
   always_comb begin
      w_a_byte    = r_a[{r_idx, 3'b000} +: 8];
      w_b_byte    = r_b[{r_idx, 3'b000} +: 8];
      w_byte_sign = r_sign & (r_idx == IDX_TOP);
   end

   comparator u_comparator (
      .i_a    (w_a_byte),
      .i_b    (w_b_byte),
      .i_sign (w_byte_sign),
      .o_eq   (w_byte_eq),
      .o_lt   (w_byte_lt),
      .o_gt   (w_byte_gt)
   );

   // Next-state and result logic; done defaults low so it only ever lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_sign_nxt  = r_sign;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      w_eq_nxt    = r_eq;
      w_lt_nxt    = r_lt;
      w_gt_nxt    = r_gt;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_a_nxt     = a_bus;
               w_b_nxt     = b_bus;
               w_sign_nxt  = sign;
               w_idx_nxt   = IDX_TOP;
               w_eq_nxt    = 1'b0;
               w_lt_nxt    = 1'b0;
               w_gt_nxt    = 1'b0;
               w_state_nxt = S_CMP;
            end
         end
         S_CMP: begin
            if (abort) begin
               // Cancelled compares leave the flags cleared and produce no done.
               w_state_nxt = S_IDLE;
            end else if (!w_byte_eq) begin
               w_lt_nxt    = w_byte_lt;
               w_gt_nxt    = w_byte_gt;
               w_eq_nxt    = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_idx == '0) begin
               w_eq_nxt    = 1'b1;
               w_lt_nxt    = 1'b0;
               w_gt_nxt    = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_idx_nxt   = r_idx - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sign  <= 1'b0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
         r_gt    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_sign  <= w_sign_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
         r_eq    <= w_eq_nxt;
         r_lt    <= w_lt_nxt;
         r_gt    <= w_gt_nxt;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      busy = (r_state == S_CMP);
      done = r_done;
      eq   = r_eq;
      lt   = r_lt;
      gt   = r_gt;
   end

endmodule

// File: tb/tb_cmp_sequencer.sv
// Bench for cmp_sequencer (NBYTES=4): vector table, directed corner cases, random vs model.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
// Every wait on done is bounded by a cycle budget.

module tb_cmp_sequencer;

   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          sign;
   logic          abort;
   logic [31:0]   a_bus;
   logic [31:0]   b_bus;
   logic          busy, done, eq, lt, gt;

   int vec_cnt = 0;
   int err_cnt = 0;

   cmp_sequencer #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sign  (sign),
      .abort (abort),
      .a_bus (a_bus),
      .b_bus (b_bus),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .lt    (lt),
      .gt    (gt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic        x_eq;
      logic        x_lt;
      logic        x_gt;
      int          x_k;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: whole-word comparison plus position of the most significant differing byte.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic m_eq, output logic m_lt, output logic m_gt,
                                 output int m_k);
      m_k = NB;
      for (int i = NB - 1; i >= 0; i--) begin
         if (((a >> (8 * i)) & 32'hFF) != ((b >> (8 * i)) & 32'hFF)) begin
            m_k = NB - i;
            break;
         end
      end
      m_eq = (a == b);
      if (s) begin
         m_lt = ($signed(a) < $signed(b));
         m_gt = ($signed(a) > $signed(b));
      end else begin
         m_lt = (a < b);
         m_gt = (a > b);
      end
   endfunction

   // Launch one compare, optionally poke start mid-compare, and measure latency and busy width.
   task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit poke, input string tag,
                          output logic r_eq, output logic r_lt, output logic r_gt,
                          output int k, output int bc);
      int edges;
      @(negedge clk);
      start = 1'b1; a_bus = a; b_bus = b; sign = s;
      @(negedge clk);
      start = 1'b0;
      a_bus = ~a; b_bus = ~b; sign = ~s;
      chk({tag, "_flags_clear"}, {29'd0, eq, lt, gt}, 32'd0);
      edges = 0;
      bc = 0;
      while (!done && edges < 20) begin
         if (busy) bc++;
         if (poke && edges == 1) begin
            start = 1'b1; a_bus = 32'h0000_0000; b_bus = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      start = 1'b0;
      chk({tag, "_timeout"}, {31'd0, edges >= 20}, 32'd0);
      k = edges;
      r_eq = eq; r_lt = lt; r_gt = gt;
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
      chk({tag, "_flags_hold"}, {29'd0, eq, lt, gt}, {29'd0, r_eq, r_lt, r_gt});
      chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
   endtask

   logic o_eq, o_lt, o_gt, m_eq, m_lt, m_gt;
   int   o_k, o_bc, m_k;

   initial begin
      tbl[0] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0, 1'b1, 1'b0, 4};
      tbl[1] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
      tbl[3] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 4};
      tbl[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 4};
      tbl[5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 4};
      tbl[6] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4};
      tbl[7] = '{32'h12FF_0000, 32'h1200_0000, 1'b1, 1'b0, 1'b0, 1'b1, 2};

      rst_n = 1'b0; start = 1'b0; sign = 1'b0; abort = 1'b0;
      a_bus = '0; b_bus = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {27'd0, busy, done, eq, lt, gt}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", {27'd0, busy, done, eq, lt, gt}, 32'd0);

      // Table of directed vectors.
      for (int i = 0; i < 8; i++) begin
         run_cmp(tbl[i].a, tbl[i].b, tbl[i].s, 1'b0, $sformatf("tbl%0d", i),
                 o_eq, o_lt, o_gt, o_k, o_bc);
         chk($sformatf("tbl%0d_result", i), {29'd0, o_eq, o_lt, o_gt},
             {29'd0, tbl[i].x_eq, tbl[i].x_lt, tbl[i].x_gt});
         chk($sformatf("tbl%0d_latency", i), o_k, tbl[i].x_k);
         chk($sformatf("tbl%0d_busy_cycles", i), o_bc, tbl[i].x_k);
      end

      // start pulsed while busy must not disturb the running compare or queue another.
      run_cmp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, "poke",
              o_eq, o_lt, o_gt, o_k, o_bc);
      chk("poke_result", {29'd0, o_eq, o_lt, o_gt}, 32'b100);
      chk("poke_latency", o_k, 4);

      // Abort on the second CMP cycle.
      @(negedge clk);
      start = 1'b1; a_bus = 32'h5555_5555; b_bus = 32'h5555_5555; sign = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy_c1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_outputs", {27'd0, busy, done, eq, lt, gt}, 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      // abort while idle is harmless
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle_noop", {27'd0, busy, done, eq, lt, gt}, 32'd0);
      run_cmp(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, "post_abort",
              o_eq, o_lt, o_gt, o_k, o_bc);
      chk("post_abort_result", {29'd0, o_eq, o_lt, o_gt}, 32'b001);
      chk("post_abort_latency", o_k, 4);

      // Asynchronous reset in the middle of a compare.
      @(negedge clk);
      start = 1'b1; a_bus = 32'hAAAA_AAAA; b_bus = 32'hAAAA_AAAA; sign = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk("midreset_outputs", {27'd0, busy, done, eq, lt, gt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_idle", {27'd0, busy, done, eq, lt, gt}, 32'd0);
      run_cmp(32'h7F00_0000, 32'h8000_0000, 1'b1, 1'b0, "post_reset",
              o_eq, o_lt, o_gt, o_k, o_bc);
      chk("post_reset_result", {29'd0, o_eq, o_lt, o_gt}, 32'b001);
      chk("post_reset_latency", o_k, 1);

      // start held high: each done is followed by an immediate accept, period k+1.
      begin
         int cyc;
         int dn[3];
         int nd;
         cyc = 0; nd = 0;
         @(negedge clk);
         start = 1'b1; a_bus = 32'h1234_5678; b_bus = 32'h1234_5679; sign = 1'b0;
         while (nd < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
               dn[nd] = cyc;
               nd++;
               chk("b2b_lt", {29'd0, eq, lt, gt}, 32'b010);
            end
         end
         start = 1'b0;
         chk("b2b_pulse_count", nd, 3);
         if (nd == 3) begin
            chk("b2b_period_1", dn[1] - dn[0], 5);
            chk("b2b_period_2", dn[2] - dn[1], 5);
         end
         cyc = 0;
         while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         chk("b2b_drain", {31'd0, busy}, 32'd0);
         repeat (2) @(negedge clk);
      end

      // Random compares against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic [31:0] ra, rb;
         logic        rs;
         int          pos;
         ra  = $urandom;
         rs  = 1'($urandom_range(0, 1));
         pos = $urandom_range(0, 4);
         rb  = ra;
         if (pos < 4) begin
            rb = ra ^ (32'($urandom_range(1, 255)) << (8 * pos));
            if ($urandom_range(0, 3) == 0) rb = rb ^ (32'h80 << (8 * pos));
            if (rb == ra) rb = ra ^ (32'h1 << (8 * pos));
         end
         model(ra, rb, rs, m_eq, m_lt, m_gt, m_k);
         run_cmp(ra, rb, rs, 1'b0, "rnd", o_eq, o_lt, o_gt, o_k, o_bc);
         chk($sformatf("rnd%0d_result a=%h b=%h s=%0d", n, ra, rb, rs),
             {29'd0, o_eq, o_lt, o_gt}, {29'd0, m_eq, m_lt, m_gt});
         chk($sformatf("rnd%0d_latency", n), o_k, m_k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
